mac_window_sequencer: RTL and testbench
=======================================

# mac_window_sequencer

Operand-feeding initiator for the hybrid approximate MAC in the edge-detection datapath. It accepts one 3x3 pixel window per valid/ready handshake and streams the nine pixel/weight pairs into the MAC one pair per cycle. The weights come from a locally held kernel register file. The block clears the MAC accumulator before each window, captures the finished accumulated sum, and presents it downstream on a valid/ready result port.

## Interface
- DATA_W, 8, pixel and weight width (unsigned)
- TAPS, 9, products per window
- ACC_W, 32, MAC result width
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- k_wr_en  in  1  kernel write strobe
- k_wr_addr  in  4  kernel tap index 0..TAPS-1
- k_wr_data  in  DATA_W  kernel weight
- win_valid  in  1  window offered
- win_ready  out  1  window accepted when win_valid & win_ready
- win_data  in  TAPS*DATA_W  pixel i at [DATA_W*i +: DATA_W]
- mac_activation  out  DATA_W  operand to MAC activation
- mac_weight  out  DATA_W  operand to MAC weight
- mac_clear  out  1  accumulator clear to MAC (flop output, glitch-free)
- mac_result  in  ACC_W  MAC accumulated result (accumulator updates on each clk edge)
- res_valid  out  1  result available
- res_ready  in  1  downstream accepts result
- res_data  out  ACC_W  captured window sum
- busy  out  1  state != IDLE

## Operation
- Kernel register file: TAPS x DATA_W, reset to 0.
  - Written on a clk edge with k_wr_en=1, only in IDLE and only for k_wr_addr < TAPS.
  - Writes are ignored while busy and for addresses TAPS..15.
- Window register: TAPS x DATA_W, loaded from win_data on the accept edge. Data is used only from this register; win_data may change after acceptance.
- FSM states: IDLE, CLEAR, FEED, DRAIN, OUT.
  - IDLE: win_ready=1. On win_valid=1 -> CLEAR and latch window.
  - CLEAR: one cycle. mac_clear=1, operands 0 -> FEED with idx=0.
  - FEED: TAPS cycles. mac_activation=pix[idx], mac_weight=w[idx], idx increments each cycle. After idx=TAPS-1 -> DRAIN.
  - DRAIN: one cycle. Operands 0. res_data <= mac_result on the exit edge -> OUT.
  - OUT: res_valid=1, res_data held. On res_ready=1 -> IDLE.
- Operands are 0 and mac_clear is 0 in every state except as listed above. A zero operand pair adds nothing to the accumulator.
- res_data is passed through from mac_result unmodified. No saturation and no sign handling.
- Kernel write and window accept on the same edge: the write takes effect, and the new weight is used in FEED.

## Timing
- Reset values:
  - Outputs: win_ready=0 while reset is asserted, 1 from the first cycle after release. mac_activation=0, mac_weight=0, mac_clear=0, res_valid=0, res_data=0, busy=0.
  - Internal: state=IDLE, kernel=0, window=0.
- Accept edge = E0. The cycle after E0 is CLEAR (cycle 1), FEED occupies cycles 2..10, DRAIN is cycle 11, and res_valid=1 from cycle 12.
- Minimum window period: 13 cycles (IDLE accept, CLEAR, 9 FEED, DRAIN, OUT with res_ready=1).
- win_ready=0 from CLEAR through OUT, including during result backpressure. No window is accepted on the res handshake edge.
- During OUT backpressure, res_valid and res_data stay stable and operands stay 0.
- Reset mid-operation: immediate return to IDLE with all outputs at reset values. The partial window is discarded and no res_valid is produced. The kernel returns to 0.

## Test plan
- Reset: assert reset mid-cycle -> all outputs 0 asynchronously. After release, win_ready=1 and busy=0.
- Bench setup for sum checks: bench MAC model is an exact accumulator (acc <= mac_clear ? 0 : acc + a*w).
- Basic sum: kernel all 1, pixels 1..9 -> mac_clear high exactly cycle 1; activation sequence 1..9 on cycles 2..10; res_valid at cycle 12 with res_data=45.
- Weighted kernel: kernel {1,2,1,0,0,0,1,2,1}, all pixels 10 -> res_data=80. Max case: all 255 -> res_data=585225.
- Backpressure: res_ready low 5 cycles in OUT -> res_valid=1 and res_data constant, win_ready=0 with win_valid=1. After the handshake, IDLE next cycle and win_ready=1.
- Kernel write rules: write tap 4=7 during FEED and write addr 12 in IDLE -> both ignored, result unchanged. Write tap 4=7 in IDLE on the accept edge -> tap 4 uses 7.
- Reset during FEED cycle 5 -> no res_valid. The next window after release gives the correct sum with kernel=0 (res_data=0) and, after reloading the kernel, the expected value.

Source files
------------

// File: rtl/mac_window_sequencer.sv
// Operand sequencer for the approximate MAC: takes one 3x3 window per handshake,
// feeds nine pixel/weight pairs, and returns the captured accumulator sum.
module mac_window_sequencer #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned TAPS   = 9,
    parameter int unsigned ACC_W  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   k_wr_en,
    input  logic [3:0]             k_wr_addr,
    input  logic [DATA_W-1:0]      k_wr_data,
    input  logic                   win_valid,
    output logic                   win_ready,
    input  logic [TAPS*DATA_W-1:0] win_data,
    output logic [DATA_W-1:0]      mac_activation,
    output logic [DATA_W-1:0]      mac_weight,
    output logic                   mac_clear,
    input  logic [ACC_W-1:0]       mac_result,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [ACC_W-1:0]       res_data,
    output logic                   busy
);

    localparam int unsigned IDX_W = 4;

    typedef enum logic [2:0] {IDLE, CLEAR, FEED, DRAIN, OUT} state_t;

    state_t            state;
    state_t            state_next;
    logic [IDX_W-1:0]  idx;
    logic [IDX_W-1:0]  idx_next;
    logic [DATA_W-1:0] kernel [TAPS];
    logic [DATA_W-1:0] window [TAPS];
    logic [DATA_W-1:0] act_next;
    logic [DATA_W-1:0] wt_next;
    logic              clear_next;
    logic              accept_c;
    logic              kwrite_c;

    assign accept_c = (state == IDLE) && win_valid;
    assign kwrite_c = k_wr_en && (state == IDLE) && (k_wr_addr < IDX_W'(TAPS));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_next;
            idx   <= idx_next;
        end
    end

    // Outputs are decoded from the next state so every operand/strobe is a flop.
    always_comb begin
        state_next = state;
        idx_next   = idx;
        act_next   = '0;
        wt_next    = '0;
        clear_next = 1'b0;
        case (state)
            IDLE:    if (win_valid) state_next = CLEAR;
            CLEAR: begin
                state_next = FEED;
                idx_next   = '0;
            end
            FEED: begin
                if (idx == IDX_W'(TAPS - 1)) state_next = DRAIN;
                else                         idx_next   = idx + 1'b1;
            end
            DRAIN:   state_next = OUT;
            OUT:     if (res_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        case (state_next)
            CLEAR: clear_next = 1'b1;
            FEED: begin
                act_next = window[idx_next];
                wt_next  = kernel[idx_next];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS; i++) kernel[i] <= '0;
        end else if (kwrite_c) begin
            kernel[k_wr_addr] <= k_wr_data;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < TAPS; i++) window[i] <= '0;
        end else if (accept_c) begin
            for (int unsigned i = 0; i < TAPS; i++) window[i] <= win_data[DATA_W*i +: DATA_W];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            win_ready      <= 1'b0;
            busy           <= 1'b0;
            res_valid      <= 1'b0;
            mac_clear      <= 1'b0;
            mac_activation <= '0;
            mac_weight     <= '0;
            res_data       <= '0;
        end else begin
            win_ready      <= (state_next == IDLE);
            busy           <= (state_next != IDLE);
            res_valid      <= (state_next == OUT);
            mac_clear      <= clear_next;
            mac_activation <= act_next;
            mac_weight     <= wt_next;
            // Accumulator holds the full sum during DRAIN.
            if (state == DRAIN) res_data <= mac_result;
        end
    end

endmodule

// File: tb/tb_mac_window_sequencer.sv
// Self-checking bench for mac_window_sequencer with an exact-accumulator MAC model
// and a sum-of-products reference for every window result.
module tb_mac_window_sequencer;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned TAPS   = 9;
    localparam int unsigned ACC_W  = 32;

    logic                   clk;
    logic                   reset;
    logic                   k_wr_en;
    logic [3:0]             k_wr_addr;
    logic [DATA_W-1:0]      k_wr_data;
    logic                   win_valid;
    logic                   win_ready;
    logic [TAPS*DATA_W-1:0] win_data;
    logic [DATA_W-1:0]      mac_activation;
    logic [DATA_W-1:0]      mac_weight;
    logic                   mac_clear;
    logic [ACC_W-1:0]       mac_result;
    logic                   res_valid;
    logic                   res_ready;
    logic [ACC_W-1:0]       res_data;
    logic                   busy;

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] kern_m [TAPS];
    logic [ACC_W-1:0]  acc;

    typedef struct {
        string                  name;
        logic [TAPS*DATA_W-1:0] pix;
        logic [TAPS*DATA_W-1:0] kern;
        int                     bp;
        logic [ACC_W-1:0]       exp_sum;
    } vec_t;

    vec_t vecs [3];

    mac_window_sequencer #(.DATA_W(DATA_W), .TAPS(TAPS), .ACC_W(ACC_W)) dut (
        .clk(clk), .reset(reset),
        .k_wr_en(k_wr_en), .k_wr_addr(k_wr_addr), .k_wr_data(k_wr_data),
        .win_valid(win_valid), .win_ready(win_ready), .win_data(win_data),
        .mac_activation(mac_activation), .mac_weight(mac_weight), .mac_clear(mac_clear),
        .mac_result(mac_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Exact accumulator standing in for the approximate MAC.
    always @(posedge clk or posedge reset) begin
        if (reset)          acc <= '0;
        else if (mac_clear) acc <= '0;
        else                acc <= acc + 32'(mac_activation) * 32'(mac_weight);
    end
    assign mac_result = acc;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    function automatic logic [ACC_W-1:0] model_sum(input logic [TAPS*DATA_W-1:0] pix);
        logic [ACC_W-1:0] s;
        s = '0;
        for (int i = 0; i < int'(TAPS); i++)
            s += 32'(pix[DATA_W*i +: DATA_W]) * 32'(kern_m[i]);
        return s;
    endfunction

    // Write one kernel tap while idle; the model keeps only in-range taps.
    task automatic write_kernel(input logic [3:0] a, input logic [DATA_W-1:0] d);
        @(negedge clk);
        k_wr_en = 1'b1; k_wr_addr = a; k_wr_data = d;
        @(negedge clk);
        k_wr_en = 1'b0;
        if (int'(a) < int'(TAPS)) kern_m[a] = d;
    endtask

    task automatic load_kernel(input logic [TAPS*DATA_W-1:0] k);
        for (int i = 0; i < int'(TAPS); i++) write_kernel(4'(i), k[DATA_W*i +: DATA_W]);
    endtask

    task automatic do_window(input string name, input logic [TAPS*DATA_W-1:0] pix,
                             input int bp, input bit feed_wr, input bit accept_wr,
                             input logic [ACC_W-1:0] exp_sum);
        @(negedge clk);
        check({name, " idle_ready"}, 64'(win_ready), 64'd1);
        win_data  = pix;
        win_valid = 1'b1;
        if (accept_wr) begin
            k_wr_en = 1'b1; k_wr_addr = 4'd4; k_wr_data = 8'd7;
        end
        @(negedge clk);
        win_valid = 1'b0;
        win_data  = 72'({$urandom(), $urandom(), $urandom()});
        k_wr_en   = 1'b0;
        check({name, " clear"}, 64'(mac_clear), 64'd1);
        check({name, " clear_ready"}, 64'(win_ready), 64'd0);
        check({name, " clear_busy"}, 64'(busy), 64'd1);
        check({name, " clear_act"}, 64'(mac_activation), 64'd0);
        for (int c = 0; c < int'(TAPS); c++) begin
            @(negedge clk);
            check({name, " feed_act"}, 64'(mac_activation), 64'(pix[DATA_W*c +: DATA_W]));
            check({name, " feed_wt"}, 64'(mac_weight), 64'(kern_m[c]));
            check({name, " feed_clear"}, 64'(mac_clear), 64'd0);
            check({name, " feed_rvalid"}, 64'(res_valid), 64'd0);
            k_wr_en   = feed_wr && (c == 2);
            k_wr_addr = 4'd4;
            k_wr_data = 8'd7;
        end
        @(negedge clk);
        k_wr_en = 1'b0;
        check({name, " drain_act"}, 64'(mac_activation), 64'd0);
        check({name, " drain_wt"}, 64'(mac_weight), 64'd0);
        check({name, " drain_rvalid"}, 64'(res_valid), 64'd0);
        @(negedge clk);
        check({name, " out_rvalid"}, 64'(res_valid), 64'd1);
        check({name, " out_data"}, 64'(res_data), 64'(exp_sum));
        res_ready = (bp == 0);
        win_valid = (bp != 0);
        for (int b = 0; b < bp; b++) begin
            @(negedge clk);
            check({name, " bp_rvalid"}, 64'(res_valid), 64'd1);
            check({name, " bp_data"}, 64'(res_data), 64'(exp_sum));
            check({name, " bp_ready"}, 64'(win_ready), 64'd0);
            check({name, " bp_ops"}, 64'({mac_activation, mac_weight}), 64'd0);
            if (b == bp - 1) begin
                res_ready = 1'b1;
                win_valid = 1'b0;
            end
        end
        @(negedge clk);
        res_ready = 1'b0;
        check({name, " post_ready"}, 64'(win_ready), 64'd1);
        check({name, " post_busy"}, 64'(busy), 64'd0);
        check({name, " post_rvalid"}, 64'(res_valid), 64'd0);
    endtask

    initial begin
        logic [TAPS*DATA_W-1:0] pix;
        logic [TAPS*DATA_W-1:0] wk;

        for (int i = 0; i < int'(TAPS); i++) kern_m[i] = '0;
        reset = 1'b1; k_wr_en = 1'b0; k_wr_addr = '0; k_wr_data = '0;
        win_valid = 1'b0; win_data = '0; res_ready = 1'b0;

        vecs[0] = '{"basic", {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1},
                    {9{8'd1}}, 0, 32'd45};
        vecs[1] = '{"weighted", {9{8'd10}},
                    {8'd1, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd1}, 1, 32'd80};
        vecs[2] = '{"max_bp", {9{8'hFF}}, {9{8'hFF}}, 5, 32'd585225};

        #3;
        check("rst win_ready", 64'(win_ready), 64'd0);
        check("rst outputs", 64'({mac_activation, mac_weight, mac_clear, res_valid, busy}), 64'd0);
        check("rst res_data", 64'(res_data), 64'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rel win_ready", 64'(win_ready), 64'd1);
        check("rel busy", 64'(busy), 64'd0);

        foreach (vecs[v]) begin
            load_kernel(vecs[v].kern);
            do_window(vecs[v].name, vecs[v].pix, vecs[v].bp, 1'b0, 1'b0, vecs[v].exp_sum);
        end

        // Ignored kernel writes: out-of-range address in IDLE and tap 4 during FEED.
        wk  = {8'd1, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd2, 8'd1};
        pix = {8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_kernel(wk);
        write_kernel(4'd12, 8'd99);
        do_window("kw_ignored", pix, 0, 1'b1, 1'b0, 32'd40);
        kern_m[4] = 8'd7;
        do_window("kw_accept", pix, 0, 1'b0, 1'b1, 32'd75);

        // Reset while feeding discards the window and clears the kernel.
        @(negedge clk);
        win_data = pix; win_valid = 1'b1;
        @(negedge clk);
        win_valid = 1'b0;
        repeat (4) @(negedge clk);
        check("mid busy", 64'(busy), 64'd1);
        reset = 1'b1;
        #1;
        check("mid rst outputs",
              64'({win_ready, mac_activation, mac_weight, mac_clear, res_valid, busy}), 64'd0);
        check("mid rst res_data", 64'(res_data), 64'd0);
        for (int i = 0; i < int'(TAPS); i++) kern_m[i] = '0;
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            check("post_rst rvalid", 64'(res_valid), 64'd0);
        end
        do_window("rst_k0", pix, 0, 1'b0, 1'b0, 32'd0);
        load_kernel(wk);
        do_window("rst_reload", pix, 1, 1'b0, 1'b0, model_sum(pix));

        // Randomized windows, kernel updates and backpressure.
        for (int n = 0; n < 20; n++) begin
            int nw;
            nw = int'($urandom_range(0, 3));
            for (int w = 0; w < nw; w++) write_kernel(4'($urandom_range(0, 15)), 8'($urandom));
            pix = 72'({$urandom(), $urandom(), $urandom()});
            do_window("rand", pix, int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                      1'b0, model_sum(pix));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
